// File: rtl/figure_pkg.sv
// Shared figure-atlas geometry: atlas dimensions, state count, and the per-state
// frame rectangle and centre tables used by both the writer and the renderer.
package figure_pkg;

  localparam int FIGURE_LENGTH = 502;
  localparam int FIGURE_WIDTH  = 424;
  localparam int NUM_STATES    = 17;
  localparam int ADDR_W        = 19;
  localparam int DIM_W         = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } fw_state_t;

  typedef struct packed {
    logic [DIM_W-1:0] corner_x;
    logic [DIM_W-1:0] corner_y;
    logic [DIM_W-1:0] frame_x;
    logic [DIM_W-1:0] frame_y;
  } frame_rect_t;

  typedef struct packed {
    logic [DIM_W-1:0] center_x;
    logic [DIM_W-1:0] center_y;
  } frame_center_t;

  localparam logic [DIM_W-1:0] CORNER_X [NUM_STATES] = '{
    9'd0,   9'd106, 9'd204, 9'd304, 9'd400, 9'd0,   9'd103, 9'd202, 9'd302,
    9'd396, 9'd0,   9'd100, 9'd198, 9'd298, 9'd0,   9'd120, 9'd396};
  localparam logic [DIM_W-1:0] CORNER_Y [NUM_STATES] = '{
    9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd160, 9'd160, 9'd160, 9'd160,
    9'd160, 9'd311, 9'd311, 9'd311, 9'd311, 9'd120, 9'd120, 9'd311};
  localparam logic [DIM_W-1:0] FRAME_X [NUM_STATES] = '{
    9'd106, 9'd98,  9'd100, 9'd96,  9'd102, 9'd103, 9'd99,  9'd100, 9'd94,
    9'd106, 9'd100, 9'd98,  9'd100, 9'd98,  9'd60,  9'd80,  9'd106};
  localparam logic [DIM_W-1:0] FRAME_Y [NUM_STATES] = '{
    9'd108, 9'd108, 9'd108, 9'd108, 9'd108, 9'd123, 9'd120, 9'd118, 9'd122,
    9'd120, 9'd110, 9'd112, 9'd108, 9'd104, 9'd38,  9'd36,  9'd110};
  localparam logic [DIM_W-1:0] CENTER_X [NUM_STATES] = '{
    9'd53,  9'd49,  9'd50,  9'd48,  9'd51,  9'd51,  9'd49,  9'd50,  9'd47,
    9'd53,  9'd50,  9'd49,  9'd50,  9'd49,  9'd30,  9'd40,  9'd53};
  localparam logic [DIM_W-1:0] CENTER_Y [NUM_STATES] = '{
    9'd54,  9'd54,  9'd54,  9'd54,  9'd54,  9'd61,  9'd60,  9'd59,  9'd61,
    9'd60,  9'd55,  9'd56,  9'd54,  9'd52,  9'd19,  9'd18,  9'd55};

  // Out-of-range indices yield an all-zero rectangle rather than reading past the table.
  function automatic frame_rect_t frame_rect(input logic [5:0] idx);
    frame_rect_t r;
    logic [4:0]  i;
    r = '0;
    i = idx[4:0];
    if (int'(idx) < NUM_STATES) begin
      r.corner_x = CORNER_X[i];
      r.corner_y = CORNER_Y[i];
      r.frame_x  = FRAME_X[i];
      r.frame_y  = FRAME_Y[i];
    end
    return r;
  endfunction

  function automatic frame_center_t frame_center(input logic [5:0] idx);
    frame_center_t c;
    logic [4:0]    i;
    c = '0;
    i = idx[4:0];
    if (int'(idx) < NUM_STATES) begin
      c.center_x = CENTER_X[i];
      c.center_y = CENTER_Y[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/figure_writer_if.sv
// Command, pixel-stream and sprite-RAM write signals of the figure writer.
interface figure_writer_if;
  import figure_pkg::*;

  logic              cmd_valid;
  logic [5:0]        cmd_state;
  logic              cmd_ready;
  logic              pix_valid;
  logic [2:0]        pix_data;
  logic              pix_ready;
  logic              abort;
  logic [ADDR_W-1:0] write_address;
  logic [2:0]        write_data;
  logic              write_en;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output cmd_valid, cmd_state, pix_valid, pix_data, abort,
    input  cmd_ready, pix_ready, write_address, write_data, write_en, busy, done, error
  );

  modport slave (
    input  cmd_valid, cmd_state, pix_valid, pix_data, abort,
    output cmd_ready, pix_ready, write_address, write_data, write_en, busy, done, error
  );
endinterface

// File: rtl/figure_addr_gen.sv
// Raster walker over one frame rectangle: holds col/row/row_base and produces the
// sprite-RAM address of the current pixel plus a last-pixel flag.
module figure_addr_gen import figure_pkg::*; #(
  parameter int FIGURE_LENGTH = figure_pkg::FIGURE_LENGTH
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load,
  input  logic              advance,
  input  frame_rect_t       rect,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FIGURE_LENGTH);

  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  corner_x_q, corner_x_d;
  logic [DIM_W-1:0]  frame_x_q, frame_x_d;
  logic [DIM_W-1:0]  frame_y_q, frame_y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              end_of_row;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    corner_x_d = corner_x_q;
    frame_x_d  = frame_x_q;
    frame_y_d  = frame_y_q;
    row_base_d = row_base_q;
    end_of_row = (col_q == frame_x_q - 9'd1);
    last       = end_of_row && (row_q == frame_y_q - 9'd1);
    if (load) begin
      col_d      = '0;
      row_d      = '0;
      corner_x_d = rect.corner_x;
      frame_x_d  = rect.frame_x;
      frame_y_d  = rect.frame_y;
      // Only multiply in the design; per-row stepping is a plain add.
      row_base_d = ADDR_W'(rect.corner_y) * STRIDE;
    end else if (advance) begin
      if (end_of_row) begin
        col_d      = '0;
        row_d      = row_q + 9'd1;
        row_base_d = row_base_q + STRIDE;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      corner_x_q <= '0;
      frame_x_q  <= '0;
      frame_y_q  <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      corner_x_q <= corner_x_d;
      frame_x_q  <= frame_x_d;
      frame_y_q  <= frame_y_d;
      row_base_q <= row_base_d;
    end
  end

  assign addr = row_base_q + ADDR_W'(corner_x_q) + ADDR_W'(col_q);

endmodule

// File: rtl/figure_writer.sv
// Loads one figure frame from a raster pixel stream into the sprite atlas RAM,
// one write per accepted pixel with a single cycle of latency.
module figure_writer import figure_pkg::*; #(
  parameter int FIGURE_LENGTH = figure_pkg::FIGURE_LENGTH,
  parameter int FIGURE_WIDTH  = figure_pkg::FIGURE_WIDTH,
  parameter int NUM_STATES    = figure_pkg::NUM_STATES,
  parameter bit SKIP_ZERO     = 1'b0
) (
  input logic             Clk,
  input logic             Reset_n,
  figure_writer_if.slave  bus
);

  if (FIGURE_LENGTH * FIGURE_WIDTH > (1 << ADDR_W) ||
      NUM_STATES > figure_pkg::NUM_STATES) begin : g_bad_cfg
    $error("figure_writer: atlas geometry or state count exceeds address/table range");
  end

  fw_state_t         state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              write_en_q, write_en_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [2:0]        write_data_q, write_data_d;

  logic              load;
  logic              pix_accept;
  logic              last;
  logic [ADDR_W-1:0] pix_addr;
  frame_rect_t       rect;

  assign rect = frame_rect(bus.cmd_state);

  figure_addr_gen #(
    .FIGURE_LENGTH(FIGURE_LENGTH)
  ) u_addr_gen (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .load   (load),
    .advance(pix_accept),
    .rect   (rect),
    .addr   (pix_addr),
    .last   (last)
  );

  always_comb begin
    state_d         = state_q;
    write_en_d      = 1'b0;
    done_d          = 1'b0;
    error_d         = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    load            = 1'b0;
    pix_accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (int'(bus.cmd_state) < NUM_STATES) begin
            state_d = LOAD;
            load    = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // abort wins over a same-cycle pixel, which is why pix_ready is masked by it.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.pix_valid) begin
          pix_accept      = 1'b1;
          write_en_d      = !(SKIP_ZERO && bus.pix_data == 3'd0);
          write_address_d = pix_addr;
          write_data_d    = bus.pix_data;
          if (last) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b0;
      write_en_q      <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      write_en_q      <= write_en_d;
      done_q          <= done_d;
      error_q         <= error_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.pix_ready     = (state_q == LOAD) && !bus.abort;
  assign bus.write_en      = write_en_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_figure_writer.sv
// Directed bench for figure_writer: an arithmetic frame model predicts every output
// each cycle; literal address/count expectations pin the model itself.
module tb_figure_writer;

  logic       Clk;
  logic       Reset_n;
  logic       cmd_valid;
  logic [5:0] cmd_state;
  logic       pix_valid;
  logic [2:0] pix_data;
  logic       abort;

  figure_writer_if u_if ();
  figure_writer_if u_if_sk ();

  assign u_if.cmd_valid    = cmd_valid;
  assign u_if.cmd_state    = cmd_state;
  assign u_if.pix_valid    = pix_valid;
  assign u_if.pix_data     = pix_data;
  assign u_if.abort        = abort;
  assign u_if_sk.cmd_valid = cmd_valid;
  assign u_if_sk.cmd_state = cmd_state;
  assign u_if_sk.pix_valid = pix_valid;
  assign u_if_sk.pix_data  = pix_data;
  assign u_if_sk.abort     = abort;

  figure_writer #(
    .FIGURE_LENGTH(502), .FIGURE_WIDTH(424), .NUM_STATES(17), .SKIP_ZERO(1'b0)
  ) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(u_if.slave)
  );

  figure_writer #(
    .FIGURE_LENGTH(502), .FIGURE_WIDTH(424), .NUM_STATES(17), .SKIP_ZERO(1'b1)
  ) u_dut_sk (
    .Clk(Clk), .Reset_n(Reset_n), .bus(u_if_sk.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Frame rectangles as the bench knows them (corner x/y, size x/y).
  int tb_cx [17] = '{0, 106, 204, 304, 400, 0, 103, 202, 302, 396, 0, 100, 198, 298, 0, 120, 396};
  int tb_cy [17] = '{0, 0, 0, 0, 0, 160, 160, 160, 160, 160, 311, 311, 311, 311, 120, 120, 311};
  int tb_fx [17] = '{106, 98, 100, 96, 102, 103, 99, 100, 94, 106, 100, 98, 100, 98, 60, 80, 106};
  int tb_fy [17] = '{108, 108, 108, 108, 108, 123, 120, 118, 122, 120, 110, 112, 108, 104, 38, 36, 110};

  // Model: mode 0 = waiting for a command, 1 = taking pixels, 2 = frame complete.
  int mode     = 0;
  bit rdy_ok   = 0;
  int k        = 0;
  int n_pix    = 0;
  int m_cx     = 0;
  int m_cy     = 0;
  int m_fx     = 1;
  bit exp_we   = 0;
  bit exp_done = 0;
  bit exp_err  = 0;
  int exp_addr = 0;
  int exp_data = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode <= 0; rdy_ok <= 0; exp_we <= 0; exp_done <= 0; exp_err <= 0;
      exp_addr <= 0; exp_data <= 0;
    end else begin
      exp_we <= 0; exp_done <= 0; exp_err <= 0;
      rdy_ok <= 1;
      if (mode == 0) begin
        if (cmd_valid && rdy_ok) begin
          if (int'(cmd_state) < 17) begin
            mode  <= 1;
            k     <= 0;
            m_cx  <= tb_cx[int'(cmd_state)];
            m_cy  <= tb_cy[int'(cmd_state)];
            m_fx  <= tb_fx[int'(cmd_state)];
            n_pix <= tb_fx[int'(cmd_state)] * tb_fy[int'(cmd_state)];
          end else begin
            exp_err <= 1;
          end
        end
      end else if (mode == 1) begin
        if (abort) begin
          mode <= 0;
        end else if (pix_valid) begin
          exp_we   <= 1;
          exp_addr <= (m_cy + k / m_fx) * 502 + m_cx + k % m_fx;
          exp_data <= int'(pix_data);
          k        <= k + 1;
          if (k + 1 == n_pix) begin
            mode     <= 2;
            exp_done <= 1;
          end
        end
      end else begin
        mode <= 0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt, done_cnt, first_addr, row2_addr, last_addr, row2_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("cmd_ready", 32'(u_if.cmd_ready), 32'((mode == 0) && rdy_ok));
    chk("pix_ready", 32'(u_if.pix_ready), 32'((mode == 1) && !abort));
    chk("busy", 32'(u_if.busy), 32'(mode != 0));
    chk("write_en", 32'(u_if.write_en), 32'(exp_we));
    chk("done", 32'(u_if.done), 32'(exp_done));
    chk("error", 32'(u_if.error), 32'(exp_err));
    if (exp_we || !Reset_n) begin
      chk("write_address", 32'(u_if.write_address), exp_addr);
      chk("write_data", 32'(u_if.write_data), exp_data);
    end
    chk("sk_write_en", 32'(u_if_sk.write_en), 32'(exp_we && exp_data != 0));
    if (exp_we && exp_data != 0) begin
      chk("sk_write_address", 32'(u_if_sk.write_address), exp_addr);
      chk("sk_write_data", 32'(u_if_sk.write_data), exp_data);
    end
    chk("sk_done", 32'(u_if_sk.done), 32'(exp_done));
    if (u_if.write_en === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(u_if.write_address);
      if (wr_cnt == row2_idx) row2_addr = int'(u_if.write_address);
      last_addr = int'(u_if.write_address);
      wr_cnt++;
    end
    if (u_if.done === 1'b1) done_cnt++;
  endtask

  task automatic tick();
    @(negedge Clk);
    check_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_stats(input int r2);
    wr_cnt = 0; done_cnt = 0; first_addr = -1; row2_addr = -1; last_addr = -1; row2_idx = r2;
  endtask

  task automatic send_cmd(input int st, input bit with_abort);
    cmd_state = 6'(st);
    cmd_valid = 1'b1;
    abort     = with_abort;
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic stream(input int n, input bit gaps);
    int sent;
    sent = 0;
    for (int c = 0; c < n * 4 + 200 && sent < n; c++) begin
      pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_data  = 3'((sent * 5 + sent / 9) % 8);
      tick();
      if (pix_valid) sent++;
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; cmd_valid = 1'b0; cmd_state = '0;
    pix_valid = 1'b0; pix_data = '0; abort = 1'b0;
    clear_stats(0);
    repeat (3) tick();
    Reset_n = 1'b1;
    repeat (2) tick();

    // Illegal states: error pulse only, no writes.
    send_cmd(17, 1'b0);
    tick();
    send_cmd(63, 1'b0);
    repeat (2) tick();
    chk("illegal_writes", wr_cnt, 0);
    chk("illegal_cmd_ready", 32'(u_if.cmd_ready), 1);

    // State 0 back-to-back; abort in IDLE and FINISH is ignored.
    clear_stats(106);
    send_cmd(0, 1'b1);
    stream(11448, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    chk("s0_writes", wr_cnt, 11448);
    chk("s0_done", done_cnt, 1);
    chk("s0_first", first_addr, 0);
    chk("s0_row2", row2_addr, 502);
    chk("s0_last", last_addr, 53819);

    // State 16, bottom-right corner of the atlas.
    clear_stats(106);
    send_cmd(16, 1'b0);
    stream(11660, 1'b0);
    repeat (3) tick();
    chk("s16_writes", wr_cnt, 11660);
    chk("s16_done", done_cnt, 1);
    chk("s16_first", first_addr, 156518);
    chk("s16_row2", row2_addr, 157020);
    chk("s16_last", last_addr, 211341);

    // State 5 with gaps in pix_valid.
    clear_stats(103);
    send_cmd(5, 1'b0);
    stream(12669, 1'b1);
    repeat (3) tick();
    chk("s5_writes", wr_cnt, 12669);
    chk("s5_done", done_cnt, 1);
    chk("s5_first", first_addr, 80320);
    chk("s5_row2", row2_addr, 80822);
    chk("s5_last", last_addr, 141666);

    // Abort after 50 pixels; the pixel offered with abort is not taken.
    clear_stats(106);
    send_cmd(0, 1'b0);
    stream(50, 1'b0);
    abort = 1'b1; pix_valid = 1'b1;
    tick();
    abort = 1'b0; pix_valid = 1'b0;
    tick();
    chk("abort_idle_busy", 32'(u_if.busy), 0);
    chk("abort_idle_cmd_ready", 32'(u_if.cmd_ready), 1);
    repeat (2) tick();
    chk("abort_writes", wr_cnt, 50);
    chk("abort_done", done_cnt, 0);
    chk("abort_last", last_addr, 49);

    // Restart at address 0, then reset mid-load drops the in-flight write.
    clear_stats(106);
    send_cmd(0, 1'b0);
    stream(20, 1'b0);
    Reset_n = 1'b0; pix_valid = 1'b1;
    tick();
    chk("rst_write_en", 32'(u_if.write_en), 0);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_pix_ready", 32'(u_if.pix_ready), 0);
    chk("rst_write_address", 32'(u_if.write_address), 0);
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_cmd_ready", 32'(u_if.cmd_ready), 1);
    pix_valid = 1'b0;
    repeat (2) tick();
    chk("restart_first", first_addr, 0);
    chk("post_rst_writes", wr_cnt, 19);
    chk("post_rst_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

endmodule
